// File: rtl/jam_solver_param.sv
// Exhaustive N-worker/N-job assignment solver: walks every job permutation in
// lexicographic order, summing costs from an external table, and keeps the best.
module jam_solver_param #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Start,
  input  logic                Mode,
  output logic                Busy,
  output logic [IDX_W-1:0]    W,
  output logic [IDX_W-1:0]    J,
  input  logic [COST_W-1:0]   Cost,
  output logic [SUM_W-1:0]    BestCost,
  output logic [CNT_W-1:0]    MatchCount,
  output logic [N*IDX_W-1:0]  BestPerm,
  output logic                Valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_CHK  = 3'd2,
    S_FIND = 3'd3,
    S_SWAP = 3'd4,
    S_REV  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_perm [N];
  logic [IDX_W-1:0]   r_w;
  logic [IDX_W-1:0]   r_anchor;
  logic [IDX_W-1:0]   r_p;
  logic [IDX_W-1:0]   r_swap;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_best;
  logic [CNT_W-1:0]   r_cnt;
  logic [N*IDX_W-1:0] r_best_perm;
  logic               r_mode;
  logic               r_first;
  logic               r_busy;
  logic               r_valid;

  logic [N*IDX_W-1:0] w_perm_flat;
  logic [IDX_W-1:0]   w_rev [N];
  logic [IDX_W-1:0]   w_j;
  logic [IDX_W-1:0]   w_pa;
  logic [IDX_W-1:0]   w_pp;
  logic [IDX_W-1:0]   w_ps;
  logic [IDX_W-1:0]   w_anchor;
  logic               w_has_anchor;
  logic               w_better;

  // Select one element of a flattened permutation by index.
  function automatic logic [IDX_W-1:0] pick(input logic [N*IDX_W-1:0] v,
                                            input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      r = (idx == IDX_W'(k)) ? v[k*IDX_W +: IDX_W] : r;
    end
    return r;
  endfunction

  // Flattened view of the permutation and the element lookups derived from it.
  always_comb begin
    w_perm_flat = {(N*IDX_W){1'b0}};
    for (int k = 0; k < N; k++) begin
      w_perm_flat[k*IDX_W +: IDX_W] = r_perm[k];
    end
    w_j  = pick(w_perm_flat, r_w);
    w_pa = pick(w_perm_flat, r_anchor);
    w_pp = pick(w_perm_flat, r_p);
    w_ps = pick(w_perm_flat, r_swap);
  end

  // Anchor search (rightmost ascent) and the comparison against the current best.
  always_comb begin
    w_anchor     = {IDX_W{1'b0}};
    w_has_anchor = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      w_anchor     = (r_perm[i] < r_perm[i+1]) ? IDX_W'(i) : w_anchor;
      w_has_anchor = (r_perm[i] < r_perm[i+1]) ? 1'b1 : w_has_anchor;
    end
    w_better = r_mode ? (r_acc > r_best) : (r_acc < r_best);
  end

  // Suffix reversal after the anchor: element k takes element N+anchor-k.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_rev[k] = r_perm[k];
      for (int m = 0; m < N; m++) begin
        w_rev[k] = ((k > int'(r_anchor)) && ((m + k) == (N + int'(r_anchor))))
                   ? r_perm[m] : w_rev[k];
      end
    end
  end

  // Main sequencer: permutation walk, cost accumulation and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      for (int k = 0; k < N; k++) begin
        r_perm[k] <= IDX_W'(k);
      end
      r_w         <= {IDX_W{1'b0}};
      r_anchor    <= {IDX_W{1'b0}};
      r_p         <= {IDX_W{1'b0}};
      r_swap      <= {IDX_W{1'b0}};
      r_acc       <= {SUM_W{1'b0}};
      r_best      <= {SUM_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_best_perm <= {(N*IDX_W){1'b0}};
      r_mode      <= 1'b0;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_mode  <= Mode;
            for (int k = 0; k < N; k++) begin
              r_perm[k] <= IDX_W'(k);
            end
            r_acc   <= {SUM_W{1'b0}};
            r_w     <= {IDX_W{1'b0}};
            r_first <= 1'b1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_acc + SUM_W'(Cost);
          if (r_w == IDX_W'(N-1)) begin
            r_w     <= {IDX_W{1'b0}};
            r_state <= S_CHK;
          end else begin
            r_w <= r_w + IDX_W'(1);
          end
        end
        S_CHK: begin
          r_first <= 1'b0;
          if (r_first || w_better) begin
            r_best      <= r_acc;
            r_cnt       <= CNT_W'(1);
            r_best_perm <= w_perm_flat;
          end else if (r_acc == r_best) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (!w_has_anchor) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_anchor <= w_anchor;
            r_p      <= w_anchor + IDX_W'(1);
            r_swap   <= w_anchor + IDX_W'(1);
            r_state  <= S_FIND;
          end
        end
        S_FIND: begin
          if ((w_pp > w_pa) && (w_pp < w_ps)) begin
            r_swap <= r_p;
          end
          if (r_p == IDX_W'(N-1)) begin
            r_state <= S_SWAP;
          end else begin
            r_p <= r_p + IDX_W'(1);
          end
        end
        S_SWAP: begin
          for (int k = 0; k < N; k++) begin
            if (r_anchor == IDX_W'(k)) begin
              r_perm[k] <= w_ps;
            end else if (r_swap == IDX_W'(k)) begin
              r_perm[k] <= w_pa;
            end
          end
          r_state <= S_REV;
        end
        S_REV: begin
          for (int k = 0; k < N; k++) begin
            r_perm[k] <= w_rev[k];
          end
          r_acc   <= {SUM_W{1'b0}};
          r_state <= S_CALC;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy       = r_busy;
  assign Valid      = r_valid;
  assign W          = r_w;
  assign J          = w_j;
  assign BestCost   = r_best;
  assign MatchCount = r_cnt;
  assign BestPerm   = r_best_perm;

endmodule

// File: tb/tb_jam_solver_param.sv
// Directed scoreboard bench for jam_solver_param using N=6, N=2 and N=3 instances.
module tb_jam_solver_param;

  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mode, start6, start2, start3;
  int   cost_sel;
  int   sel;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic       busy6, valid6;
  logic [2:0] w6, j6;
  logic [6:0] cost6;
  logic [9:0] best6;
  logic [15:0] cnt6;
  logic [17:0] perm6;

  logic       busy2, valid2;
  logic [0:0] w2, j2;
  logic [6:0] cost2;
  logic [7:0] best2;
  logic [3:0] cnt2;
  logic [1:0] perm2;

  logic       busy3, valid3;
  logic [1:0] w3, j3;
  logic [6:0] cost3;
  logic [8:0] best3;
  logic [3:0] cnt3;
  logic [5:0] perm3;

  jam_solver_param #(.N(6), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) dut6 (
    .CLK(clk), .RST_N(rst_n), .Start(start6), .Mode(mode), .Busy(busy6),
    .W(w6), .J(j6), .Cost(cost6), .BestCost(best6), .MatchCount(cnt6),
    .BestPerm(perm6), .Valid(valid6));

  jam_solver_param #(.N(2), .IDX_W(1), .COST_W(7), .SUM_W(8), .CNT_W(4)) dut2 (
    .CLK(clk), .RST_N(rst_n), .Start(start2), .Mode(mode), .Busy(busy2),
    .W(w2), .J(j2), .Cost(cost2), .BestCost(best2), .MatchCount(cnt2),
    .BestPerm(perm2), .Valid(valid2));

  jam_solver_param #(.N(3), .IDX_W(2), .COST_W(7), .SUM_W(9), .CNT_W(4)) dut3 (
    .CLK(clk), .RST_N(rst_n), .Start(start3), .Mode(mode), .Busy(busy3),
    .W(w3), .J(j3), .Cost(cost3), .BestCost(best3), .MatchCount(cnt3),
    .BestPerm(perm3), .Valid(valid3));

  always_comb begin
    cost6 = (cost_sel == 0) ? 7'd5 : ((w6 == j6) ? 7'd0 : 7'd10);
    cost2 = (w2 == j2) ? 7'd1 : 7'd5;
    cost3 = {5'd0, w3} * {5'd0, j3};
  end

  logic        obs_busy, obs_valid;
  logic [31:0] obs_best, obs_cnt, obs_perm;
  always_comb begin
    case (sel)
      1: begin
        obs_busy = busy2; obs_valid = valid2;
        obs_best = 32'(best2); obs_cnt = 32'(cnt2); obs_perm = 32'(perm2);
      end
      2: begin
        obs_busy = busy3; obs_valid = valid3;
        obs_best = 32'(best3); obs_cnt = 32'(cnt3); obs_perm = 32'(perm3);
      end
      default: begin
        obs_busy = busy6; obs_valid = valid6;
        obs_best = 32'(best6); obs_cnt = 32'(cnt6); obs_perm = 32'(perm6);
      end
    endcase
  end

  typedef struct packed {
    logic [31:0] best;
    logic [31:0] cnt;
    logic [31:0] perm;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int w, input int a0, input int a1,
                                     input int a2 = 0, input int a3 = 0,
                                     input int a4 = 0, input int a5 = 0);
    return 32'(a0) | (32'(a1) << w) | (32'(a2) << (2*w)) | (32'(a3) << (3*w))
         | (32'(a4) << (4*w)) | (32'(a5) << (5*w));
  endfunction

  task automatic push_exp(input logic [31:0] b, input logic [31:0] c, input logic [31:0] p);
    exp_t e;
    e.best = b; e.cnt = c; e.perm = p;
    sb.push_back(e);
  endtask

  task automatic start_run(input string tag, input int s, input logic md);
    sel = s;
    @(negedge clk);
    mode = md;
    start6 = (s == 0); start2 = (s == 1); start3 = (s == 2);
    @(negedge clk);
    start6 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    check({tag, "_busy_on_start"}, 32'(obs_busy), 32'd1);
    check({tag, "_valid_cleared"}, 32'(obs_valid), 32'd0);
  endtask

  task automatic finish_run(input string tag, output int cycles);
    exp_t e;
    bit dropped;
    cycles = 0;
    dropped = 1'b0;
    while (obs_valid !== 1'b1 && cycles < BUDGET) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (obs_valid !== 1'b1 && obs_busy !== 1'b1) dropped = 1'b1;
    end
    if (cycles >= BUDGET) check({tag, "_timeout"}, 32'd0, 32'd1);
    e = sb.pop_front();
    check({tag, "_best"}, obs_best, e.best);
    check({tag, "_count"}, obs_cnt, e.cnt);
    check({tag, "_perm"}, obs_perm, e.perm);
    check({tag, "_valid"}, 32'(obs_valid), 32'd1);
    check({tag, "_busy_low"}, 32'(obs_busy), 32'd0);
    check({tag, "_busy_held"}, 32'(dropped), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] id6;
    id6 = pk(3, 0, 1, 2, 3, 4, 5);
    rst_n = 1'b0; mode = 1'b0; start6 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    cost_sel = 0; sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy6), 32'd0);
    check("rst_valid", 32'(valid6), 32'd0);
    check("rst_best", 32'(best6), 32'd0);
    check("rst_count", 32'(cnt6), 32'd0);
    check("rst_perm", 32'(perm6), 32'd0);
    check("rst_w", 32'(w6), 32'd0);
    check("rst_j", 32'(j6), 32'd0);

    // Uniform cost: every permutation ties.
    push_exp(32'd30, 32'd720, id6);
    start_run("flat", 0, 1'b0);
    finish_run("flat", cyc);

    // Diagonal-zero table, minimise then maximise without reset.
    cost_sel = 1;
    push_exp(32'd0, 32'd1, id6);
    start_run("diag_min", 0, 1'b0);
    finish_run("diag_min", cyc);
    push_exp(32'd60, 32'd265, pk(3, 1, 0, 3, 2, 5, 4));
    start_run("diag_max", 0, 1'b1);
    finish_run("diag_max", cyc);

    // N=2 with exact latency.
    push_exp(32'd2, 32'd1, pk(1, 0, 1));
    start_run("n2_min", 1, 1'b0);
    finish_run("n2_min", cyc);
    check("n2_latency", 32'(cyc), 32'd9);
    push_exp(32'd10, 32'd1, pk(1, 1, 0));
    start_run("n2_max", 1, 1'b1);
    finish_run("n2_max", cyc);

    // N=3 with cost W*J.
    push_exp(32'd1, 32'd1, pk(2, 2, 1, 0));
    start_run("n3_min", 2, 1'b0);
    finish_run("n3_min", cyc);
    push_exp(32'd5, 32'd1, pk(2, 0, 1, 2));
    start_run("n3_max", 2, 1'b1);
    finish_run("n3_max", cyc);

    // Start and Mode pulsed during CALC must be ignored.
    cost_sel = 0;
    push_exp(32'd30, 32'd720, id6);
    start_run("midstart", 0, 1'b0);
    @(negedge clk);
    mode = 1'b1; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0; mode = 1'b0;
    check("midstart_busy", 32'(busy6), 32'd1);
    finish_run("midstart", cyc);

    // Reset while in FIND of the first permutation, then a clean rerun.
    start_run("abort", 0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("abort_pre_busy", 32'(busy6), 32'd1);
    check("abort_pre_best", 32'(best6), 32'd30);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy6), 32'd0);
    check("abort_valid", 32'(valid6), 32'd0);
    check("abort_best", 32'(best6), 32'd0);
    check("abort_count", 32'(cnt6), 32'd0);
    check("abort_perm", 32'(perm6), 32'd0);
    check("abort_w", 32'(w6), 32'd0);
    check("abort_j", 32'(j6), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'd30, 32'd720, id6);
    start_run("after_abort", 0, 1'b0);
    finish_run("after_abort", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_solver_param.md
Name: jam_solver_param

Overview:
- Exhaustive N-worker/N-job assignment solver. It walks every permutation of jobs in lexicographic order and fetches each worker/job cost from an external combinational cost table.
- Reports the best total cost (minimum or maximum, selectable), how many permutations achieve it, and the first permutation that achieved it.
- Parametrised successor of the fixed 8x8 minimum-cost solver. Adds a Start/Busy handshake so the block can be rerun without reset.

Parameters:
- N, 8, workers = jobs; legal 2..8.
- IDX_W, 3, index width; must satisfy 2^IDX_W >= N.
- COST_W, 7, width of one cost entry.
- SUM_W, 10, accumulator width; must hold N*(2^COST_W-1).
- CNT_W, 16, match counter width; must hold N!.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Start  in  1  begin a run; sampled only in IDLE or DONE.
- Mode  in  1  0 = minimise, 1 = maximise; sampled with Start.
- Busy  out  1  high from the accepted Start until DONE.
- W  out  IDX_W  worker index presented to cost table.
- J  out  IDX_W  job index for worker W, i.e. Perm[W].
- Cost  in  COST_W  table output for (W,J); combinational, valid in the same cycle.
- BestCost  out  SUM_W  best total found.
- MatchCount  out  CNT_W  number of permutations equal to BestCost.
- BestPerm  out  N*IDX_W  job for worker k at bits [k*IDX_W +: IDX_W]; first permutation (lexicographic) reaching BestCost.
- Valid  out  1  results final; held until next accepted Start.

Behaviour:
- Reset (async, RST_N=0): state IDLE; Perm = identity; W=0, J=0, Busy=0, Valid=0, BestCost=0, MatchCount=0, BestPerm=0.
- States: IDLE, CALC, CHK, FIND, SWAP, REV, DONE.
- IDLE or DONE with Start=1:
  - latch Mode; Perm = identity; clear accumulator; go to CALC.
  - Busy goes 1 and Valid goes 0 at that edge.
- Start in any other state is ignored.
- CALC: exactly N cycles, W = 0..N-1.
  - Accumulator += Cost each cycle; Cost is zero-extended to SUM_W.
  - Anchor = largest i < N-1 with Perm[i] < Perm[i+1]; "none" if Perm is descending.
- CHK: 1 cycle; update the result registers:
  - First permutation of the run: load BestCost = sum, MatchCount = 1, BestPerm = Perm.
  - Otherwise, if sum is strictly better (less for Mode 0, greater for Mode 1): load BestCost, BestPerm, MatchCount = 1.
  - Otherwise, if sum equals BestCost: MatchCount += 1; BestPerm unchanged.
  - Otherwise: no change.
  - Next state: DONE if anchor is "none", else FIND.
- FIND: one cycle per index p = anchor+1..N-1 (N-1-anchor cycles). Tracks swap = index of the smallest Perm[p] greater than Perm[anchor].
- SWAP: 1 cycle; exchange Perm[anchor] and Perm[swap].
- REV: 1 cycle; reverse Perm[anchor+1..N-1]; clear accumulator; go to CALC.
- DONE: Busy=0, Valid=1; W=0; results held; wait for Start.
- W is 0 outside CALC; J = Perm[W] at all times.
- Mode changes mid-run have no effect.
- Reset mid-run aborts immediately to reset values.
- N=2 latency: Start sampled at edge e0 -> Valid and Busy=0 first seen after edge e9.
- General run length: sum over permutations of (N+1) cycles for CALC+CHK, plus FIND+SWAP+REV cycles for every permutation except the last.

Test Plan:
1. N=8, Mode 0, Cost=5 for all (W,J) -> BestCost=40, MatchCount=40320, BestPerm=identity (worker k -> job k), Valid high, Busy low.
2. N=8, Cost=0 if W==J else 10.
   - Mode 0 -> BestCost=0, MatchCount=1, BestPerm=identity.
   - Rerun with Start, Mode 1 -> BestCost=80, MatchCount=14833, BestPerm = {1,0,3,2,5,4,7,6}.
3. N=2, cost C[0][0]=C[1][1]=1, C[0][1]=C[1][0]=5.
   - Mode 0 -> BestCost=2, MatchCount=1, BestPerm={0,1}, Valid after exactly 9 edges.
   - Mode 1 -> BestCost=10, BestPerm={1,0}.
4. Pulse Start mid-run during CALC -> ignored; results identical to scenario 1; Busy stays high until DONE.
5. Assert RST_N=0 during FIND of a run -> all outputs at reset values immediately; new Start -> correct full result.
6. N=3, Cost=W*J (COST_W=7) -> Mode 0: BestCost=1, MatchCount=1, BestPerm={2,1,0}; Mode 1: BestCost=5, MatchCount=1, BestPerm={0,1,2}.
